// File: rtl/ef_uart_wb_tx_arbiter.sv
// ef_uart_wb_tx_arbiter: configures one EF_UART_wb over Wishbone after reset,
// then round-robin shares its TX FIFO among NUM_REQ byte requesters.
// Optional feature macro: WB_TIMEOUT_EN adds a bus-ack timeout and a sticky err_o.
module ef_uart_wb_tx_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned PRESCALE = 2,
    parameter int unsigned POLL_GAP = 4,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [2:0]             grant_id,
    output logic                   busy,
    output logic                   init_done,
    output logic [31:0]            adr_o,
    output logic [31:0]            dat_o,
    input  logic [31:0]            dat_i,
    output logic [3:0]             sel_o,
    output logic                   cyc_o,
    output logic                   stb_o,
    output logic                   we_o,
`ifdef WB_TIMEOUT_EN
    output logic                   err_o,
`endif
    input  logic                   ack_i
);

    localparam int unsigned CNT_W = 16;
    localparam logic [31:0] ADR_DATA = 32'h0000_0000;
    localparam logic [31:0] ADR_PRE  = 32'h0000_0004;
    localparam logic [31:0] ADR_CTRL = 32'h0000_0100;
    localparam logic [31:0] ADR_RIS  = 32'h0000_0200;
    localparam logic [31:0] ADR_IM   = 32'h0000_0208;
    localparam logic [31:0] ADR_ICR  = 32'h0000_020C;

    typedef enum logic [3:0] {
        S_CFG_PRE, S_CFG_IM, S_CFG_ICR, S_CFG_CTRL,
        S_IDLE, S_POLL, S_CHECK, S_GAP, S_WRITE
    } state_t;

    state_t             r_state, w_state_nxt;
    logic               r_cyc, w_cyc_nxt;
    logic               r_we, w_we_nxt;
    logic [31:0]        r_adr, w_adr_nxt;
    logic [31:0]        r_dat, w_dat_nxt;
    logic [NUM_REQ-1:0] r_ready, w_ready_nxt;
    logic [2:0]         r_grant, w_grant_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_init, w_init_nxt;
    logic [2:0]         r_ptr, w_ptr_nxt;
    logic [7:0]         r_hold, w_hold_nxt;
    logic               r_full, w_full_nxt;
    logic [CNT_W-1:0]   r_gap, w_gap_nxt;

    logic               w_done, w_tmo, w_launch, w_l_we;
    logic [31:0]        w_l_adr, w_l_dat;
    logic [2:0]         w_ptr_adv;
    logic [NUM_REQ-1:0] w_rot;
    logic               w_found;
    logic [3:0]         w_sum;
    logic [2:0]         w_win;
    logic [7:0]         w_byte;

`ifdef WB_TIMEOUT_EN
    logic [CNT_W-1:0]   r_to_cnt, w_to_nxt;
    logic               r_err, w_err_nxt;
    logic               w_unused;
    assign w_unused = &{1'b0, dat_i[31:1]};
    assign w_tmo    = r_cyc & ~ack_i & (r_to_cnt == CNT_W'(TIMEOUT - 1));
    assign w_to_nxt = (r_cyc && !ack_i && !w_tmo) ? r_to_cnt + CNT_W'(1) : '0;
    assign w_err_nxt = r_err | w_tmo;
    assign err_o    = r_err;
`else
    logic               w_unused;
    assign w_unused = &{1'b0, dat_i[31:1], 32'(TIMEOUT)};
    assign w_tmo    = 1'b0;
`endif

    assign w_done    = r_cyc & ack_i;
    assign w_ptr_adv = (r_grant == 3'(NUM_REQ - 1)) ? 3'd0 : r_grant + 3'd1;

    assign cyc_o     = r_cyc;
    assign stb_o     = r_cyc;
    assign we_o      = r_we;
    assign adr_o     = r_adr;
    assign dat_o     = r_dat;
    assign sel_o     = 4'hF;
    assign req_ready = r_ready;
    assign grant_id  = r_grant;
    assign busy      = r_busy;
    assign init_done = r_init;

    // Round-robin winner: first valid requester at or after the pointer.
    always_comb begin
        w_rot   = NUM_REQ'({req_valid, req_valid} >> r_ptr);
        w_found = 1'b0;
        w_sum   = '0;
        w_win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = 4'(r_ptr) + 4'(k);
                w_win   = (w_sum >= 4'(NUM_REQ)) ? 3'(w_sum - 4'(NUM_REQ)) : 3'(w_sum);
            end
        end
        w_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == 3'(i)) w_byte = req_data[8*i +: 8];
        end
    end

    // Next-state and registered-output logic; bus strobes launch from a cycle with cyc low.
    always_comb begin
        w_state_nxt = r_state;
        w_cyc_nxt   = r_cyc;
        w_we_nxt    = r_we;
        w_adr_nxt   = r_adr;
        w_dat_nxt   = r_dat;
        w_ready_nxt = '0;
        w_grant_nxt = r_grant;
        w_busy_nxt  = r_busy;
        w_init_nxt  = r_init;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold;
        w_full_nxt  = r_full;
        w_gap_nxt   = r_gap;
        w_launch    = 1'b0;
        w_l_we      = 1'b0;
        w_l_adr     = '0;
        w_l_dat     = '0;

        if (w_done || w_tmo) w_cyc_nxt = 1'b0;

        case (r_state)
            S_CFG_PRE: begin
                if (!r_cyc) begin
                    w_launch = 1'b1; w_l_we = 1'b1; w_l_adr = ADR_PRE; w_l_dat = 32'(PRESCALE);
                end else if (w_done) w_state_nxt = S_CFG_IM;
            end
            S_CFG_IM: begin
                if (!r_cyc) begin
                    w_launch = 1'b1; w_l_we = 1'b1; w_l_adr = ADR_IM; w_l_dat = 32'h0;
                end else if (w_done) w_state_nxt = S_CFG_ICR;
            end
            S_CFG_ICR: begin
                if (!r_cyc) begin
                    w_launch = 1'b1; w_l_we = 1'b1; w_l_adr = ADR_ICR; w_l_dat = 32'hFF;
                end else if (w_done) w_state_nxt = S_CFG_CTRL;
            end
            S_CFG_CTRL: begin
                if (!r_cyc) begin
                    w_launch = 1'b1; w_l_we = 1'b1; w_l_adr = ADR_CTRL; w_l_dat = 32'h7;
                end else if (w_done) begin
                    w_init_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (r_init && w_found) begin
                    w_ready_nxt[w_win] = 1'b1;
                    w_hold_nxt  = w_byte;
                    w_grant_nxt = w_win;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_POLL;
                end
            end
            S_POLL: begin
                if (!r_cyc) begin
                    w_launch = 1'b1; w_l_we = 1'b0; w_l_adr = ADR_RIS; w_l_dat = 32'h0;
                end else if (w_done) begin
                    w_full_nxt  = dat_i[0];
                    w_state_nxt = S_CHECK;
                end else if (w_tmo) begin
                    w_busy_nxt  = 1'b0;
                    w_ptr_nxt   = w_ptr_adv;
                    w_state_nxt = S_IDLE;
                end
            end
            S_CHECK: begin
                if (r_full) begin
                    w_gap_nxt   = '0;
                    w_state_nxt = S_GAP;
                end else begin
                    w_launch = 1'b1; w_l_we = 1'b1; w_l_adr = ADR_DATA; w_l_dat = {24'h0, r_hold};
                    w_state_nxt = S_WRITE;
                end
            end
            S_GAP: begin
                if (r_gap >= CNT_W'(POLL_GAP - 1)) w_state_nxt = S_POLL;
                else w_gap_nxt = r_gap + CNT_W'(1);
            end
            S_WRITE: begin
                if (!r_cyc) begin
                    w_launch = 1'b1; w_l_we = 1'b1; w_l_adr = ADR_DATA; w_l_dat = {24'h0, r_hold};
                end else if (w_done || w_tmo) begin
                    w_busy_nxt  = 1'b0;
                    w_ptr_nxt   = w_ptr_adv;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_CFG_PRE;
        endcase

        if (w_launch) begin
            w_cyc_nxt = 1'b1;
            w_we_nxt  = w_l_we;
            w_adr_nxt = w_l_adr;
            w_dat_nxt = w_l_dat;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_CFG_PRE;
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_ready <= '0;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_init  <= 1'b0;
            r_ptr   <= '0;
            r_hold  <= '0;
            r_full  <= 1'b0;
            r_gap   <= '0;
`ifdef WB_TIMEOUT_EN
            r_to_cnt <= '0;
            r_err    <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cyc   <= w_cyc_nxt;
            r_we    <= w_we_nxt;
            r_adr   <= w_adr_nxt;
            r_dat   <= w_dat_nxt;
            r_ready <= w_ready_nxt;
            r_grant <= w_grant_nxt;
            r_busy  <= w_busy_nxt;
            r_init  <= w_init_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= w_hold_nxt;
            r_full  <= w_full_nxt;
            r_gap   <= w_gap_nxt;
`ifdef WB_TIMEOUT_EN
            r_to_cnt <= w_to_nxt;
            r_err    <= w_err_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_ef_uart_wb_tx_arbiter.sv
// Directed bench for ef_uart_wb_tx_arbiter with a registered-ack Wishbone slave.
module tb_ef_uart_wb_tx_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [2:0]  grant_id;
    logic        busy, init_done;
    logic [31:0] adr_o, dat_o, dat_i;
    logic [3:0]  sel_o;
    logic        cyc_o, stb_o, we_o;
    logic        ack_i;
`ifdef WB_TIMEOUT_EN
    logic        err_o;
`endif

    ef_uart_wb_tx_arbiter #(.NUM_REQ(4), .PRESCALE(2), .POLL_GAP(4), .TIMEOUT(255)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .grant_id(grant_id), .busy(busy), .init_done(init_done),
        .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .sel_o(sel_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
`ifdef WB_TIMEOUT_EN
        .err_o(err_o),
`endif
        .ack_i(ack_i)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc_n    = 0;
    int          n_log    = 0;
    int          busy_cnt = 0;
    int          rdy_cnt [4];
    logic [2:0]  last_grant = '0;
    logic [31:0] log_adr [64];
    logic [31:0] log_dat [64];
    logic        log_we  [64];
    int          log_cyc [64];
    int          ris_reads = 0;
    int          ris_limit = 0;
    logic        hold_ack  = 1'b0;
    int          base;

    assign dat_i = {31'h0, (ris_reads < ris_limit)};

    // Slave: ack one cycle after strobe; optionally withholds ack for DATA writes.
    always @(posedge clk_i) begin
        cyc_n <= cyc_n + 1;
        if (rst_i) ack_i <= 1'b0;
        else ack_i <= cyc_o & stb_o & ~ack_i & ~(hold_ack & we_o & (adr_o == 32'h0));
        if (cyc_o && stb_o && ack_i && !we_o) ris_reads <= ris_reads + 1;
    end

    // Monitor away from the active edge: transaction log, busy time, ready pulses.
    always @(negedge clk_i) begin
        if (cyc_o && stb_o && ack_i && n_log < 64) begin
            log_adr[n_log] = adr_o;
            log_dat[n_log] = dat_o;
            log_we[n_log]  = we_o;
            log_cyc[n_log] = cyc_n;
            n_log++;
        end
        if (busy === 1'b1) busy_cnt++;
        for (int i = 0; i < 4; i++) begin
            if (req_ready[i] === 1'b1) begin
                rdy_cnt[i]++;
                last_grant   = grant_id;
                req_valid[i] = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_init(input int budget);
        int t = 0;
        while (init_done !== 1'b1 && t < budget) begin
            @(negedge clk_i);
            t++;
        end
        check_eq("init_wait", 32'(init_done), 32'h1);
    endtask

    task automatic wait_log(input int target, input int budget, input string tag);
        int t = 0;
        while (n_log < target && t < budget) begin
            @(negedge clk_i);
            t++;
        end
        check_eq(tag, 32'(n_log >= target), 32'h1);
    endtask

    task automatic check_cfg(input int b);
        check_eq("cfg0_adr", log_adr[b],   32'h0004); check_eq("cfg0_dat", log_dat[b],   32'h2);
        check_eq("cfg1_adr", log_adr[b+1], 32'h0208); check_eq("cfg1_dat", log_dat[b+1], 32'h0);
        check_eq("cfg2_adr", log_adr[b+2], 32'h020C); check_eq("cfg2_dat", log_dat[b+2], 32'hFF);
        check_eq("cfg3_adr", log_adr[b+3], 32'h0100); check_eq("cfg3_dat", log_dat[b+3], 32'h7);
        for (int k = 0; k < 4; k++) check_eq("cfg_we", 32'(log_we[b+k]), 32'h1);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) rdy_cnt[i] = 0;
        rst_i     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        repeat (3) @(negedge clk_i);
        check_eq("rst_cyc",   32'(cyc_o),     32'h0);
        check_eq("rst_stb",   32'(stb_o),     32'h0);
        check_eq("rst_we",    32'(we_o),      32'h0);
        check_eq("rst_adr",   adr_o,          32'h0);
        check_eq("rst_dat",   dat_o,          32'h0);
        check_eq("rst_ready", 32'(req_ready), 32'h0);
        check_eq("rst_grant", 32'(grant_id),  32'h0);
        check_eq("rst_busy",  32'(busy),      32'h0);
        check_eq("rst_init",  32'(init_done), 32'h0);
        check_eq("sel",       32'(sel_o),     32'hF);

        // Configuration sequence after reset release, then silence while idle.
        base  = n_log;
        rst_i = 1'b0;
        wait_init(100);
        check_eq("cfg_count", 32'(n_log - base), 32'd4);
        check_cfg(base);
        repeat (20) @(negedge clk_i);
        check_eq("idle_quiet", 32'(n_log - base), 32'd4);

        // Single byte from requester 2, FIFO not full.
        base = n_log; busy_cnt = 0;
        req_data[23:16] = 8'h5A;
        req_valid[2]    = 1'b1;
        wait_log(base + 2, 50, "single_wait");
        repeat (3) @(negedge clk_i);
        check_eq("single_rdy",   32'(rdy_cnt[2]), 32'd1);
        check_eq("single_grant", 32'(last_grant), 32'd2);
        check_eq("single_radr",  log_adr[base],   32'h0200);
        check_eq("single_rwe",   32'(log_we[base]), 32'h0);
        check_eq("single_wadr",  log_adr[base+1], 32'h0000);
        check_eq("single_wdat",  log_dat[base+1], 32'h0000005A);
        check_eq("single_wwe",   32'(log_we[base+1]), 32'h1);
        check_eq("single_busy",  32'(busy_cnt),   32'd6);
        check_eq("single_count", 32'(n_log - base), 32'd2);

        // Fresh pointer, all four requesters at once.
        do_reset();
        wait_init(100);
        base = n_log;
        req_data  = 32'h44332211;
        req_valid = 4'hF;
        wait_log(base + 8, 200, "all4_wait");
        check_eq("all4_w0", log_dat[base+1], 32'h11);
        check_eq("all4_w1", log_dat[base+3], 32'h22);
        check_eq("all4_w2", log_dat[base+5], 32'h33);
        check_eq("all4_w3", log_dat[base+7], 32'h44);
        req_data  = 32'hD30000A0;
        req_valid = 4'b1001;
        wait_log(base + 12, 100, "rr_wait");
        check_eq("rr_first",  log_dat[base+9],  32'hA0);
        check_eq("rr_second", log_dat[base+11], 32'hD3);

        // FIFO full for three polls, then clear.
        repeat (5) @(negedge clk_i);
        base = n_log;
        ris_limit = ris_reads + 3;
        req_data[15:8] = 8'h77;
        req_valid[1]   = 1'b1;
        wait_log(base + 5, 300, "full_wait");
        for (int k = 0; k < 4; k++) begin
            check_eq("full_radr", log_adr[base+k], 32'h0200);
            check_eq("full_rwe",  32'(log_we[base+k]), 32'h0);
        end
        for (int k = 1; k < 4; k++)
            check_eq("full_gap", 32'((log_cyc[base+k] - log_cyc[base+k-1]) >= 7), 32'h1);
        check_eq("full_wadr", log_adr[base+4], 32'h0000);
        check_eq("full_wdat", log_dat[base+4], 32'h77);
        repeat (10) @(negedge clk_i);
        check_eq("full_count", 32'(n_log - base), 32'd5);

        // Reset while a DATA write is stalled.
        hold_ack = 1'b1;
        req_data[7:0] = 8'h99;
        req_valid[0]  = 1'b1;
        begin
            int t = 0;
            while (!(cyc_o && stb_o && we_o && adr_o == 32'h0) && t < 50) begin
                @(negedge clk_i);
                t++;
            end
            check_eq("stall_seen", 32'(cyc_o & we_o & (adr_o == 32'h0)), 32'h1);
        end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check_eq("mid_rst_cyc",  32'(cyc_o),     32'h0);
        check_eq("mid_rst_stb",  32'(stb_o),     32'h0);
        check_eq("mid_rst_init", 32'(init_done), 32'h0);
        check_eq("mid_rst_busy", 32'(busy),      32'h0);
        rst_i    = 1'b0;
        hold_ack = 1'b0;
        base     = n_log;
        wait_init(100);
        check_cfg(base);
        repeat (20) @(negedge clk_i);
        check_eq("mid_rst_count", 32'(n_log - base), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
